// File: rtl/memshare_vn_iblut_loader_mb.sv
// memshare_vn_iblut_loader_mb
// Parametrised VN IB-LUT with an on-block remap loader and a handshaked lookup port.
// The remap stream writes one page (all banks) per accepted word. Once every page has
// been written the table goes valid and lookups return the stored message.
// Optional feature macro: IBLUT_OUT_REG_EN adds an output register stage, which makes
// the lookup latency and lkup_err_o latency 2 cycles instead of 1.
module memshare_vn_iblut_loader_mb #(
  parameter int BANK_NUM    = 2,
  parameter int ADDR_WIDTH  = 6,
  parameter int MSG_WIDTH   = 4,
  parameter int SHARE_GROUP = 1
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          load_start_i,
  input  logic                          remap_valid_i,
  input  logic [BANK_NUM*MSG_WIDTH-1:0] remap_data_i,
  output logic                          remap_ready_o,
  output logic                          load_done_o,
  output logic                          table_valid_o,
  input  logic                          lkup_valid_i,
  input  logic [ADDR_WIDTH-1:0]         lkup_addr_i,
  output logic [MSG_WIDTH-1:0]          msg_o,
  output logic                          msg_valid_o,
  output logic                          lkup_err_o,
  output logic [1:0]                    grp_o
);

  localparam int BANK_W   = $clog2(BANK_NUM);
  localparam int PAGE_NUM = (2 ** ADDR_WIDTH) / BANK_NUM;
  localparam int PAGE_W   = ADDR_WIDTH - BANK_W;
  localparam int CNT_W    = $clog2(PAGE_NUM) + 1;

  localparam logic [CNT_W-1:0] LAST_PAGE = CNT_W'(PAGE_NUM - 1);
  localparam logic [CNT_W-1:0] PAGE_LIM  = CNT_W'(PAGE_NUM);

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    ACTIVE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]                   page_cnt;
  logic                               accept;
  logic                               last_accept;
  logic                               lkup_hit;
  logic                               lkup_miss;
  logic [BANK_W-1:0]                  lk_bank;
  logic [PAGE_W-1:0]                  lk_page;
  logic [BANK_NUM-1:0][MSG_WIDTH-1:0] rd;

  logic [MSG_WIDTH-1:0]               msg_q1;
  logic                               vld_q1;
  logic                               err_q1;

  assign grp_o         = 2'(SHARE_GROUP);
  assign table_valid_o = (state == ACTIVE);
  // The count guard keeps page_cnt from ever passing PAGE_NUM, even if the
  // state transition were somehow delayed.
  assign remap_ready_o = (state == LOAD) && (page_cnt < PAGE_LIM);
  assign accept        = remap_valid_i && remap_ready_o;
  assign last_accept   = accept && (page_cnt == LAST_PAGE);
  assign lkup_hit      = lkup_valid_i && (state == ACTIVE);
  assign lkup_miss     = lkup_valid_i && (state != ACTIVE);
  assign lk_bank       = lkup_addr_i[BANK_W-1:0];
  assign lk_page       = lkup_addr_i[ADDR_WIDTH-1:BANK_W];

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next-state logic; a load restart takes priority over completing the table
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load_start_i) state_nxt = LOAD;
      LOAD: begin
        if (load_start_i)     state_nxt = LOAD;
        else if (last_accept) state_nxt = ACTIVE;
      end
      ACTIVE:  if (load_start_i) state_nxt = LOAD;
      default: state_nxt = EMPTY;
    endcase
  end

  // Page counter and load-done pulse
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      page_cnt    <= '0;
      load_done_o <= 1'b0;
    end else begin
      load_done_o <= last_accept && !load_start_i;
      if (load_start_i) page_cnt <= '0;
      else if (accept)  page_cnt <= page_cnt + 1'b1;
    end
  end

  // One storage array per bank; all banks are written at the same page
  for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
    logic [MSG_WIDTH-1:0] ram [PAGE_NUM];

    // Bank write, contents deliberately not reset
    always_ff @(posedge sys_clk) begin
      if (accept) ram[page_cnt[PAGE_W-1:0]] <= remap_data_i[g*MSG_WIDTH +: MSG_WIDTH];
    end

    assign rd[g] = ram[lk_page];
  end

  // Registered lookup read; msg holds its last value when no hit occurs
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      msg_q1 <= '0;
      vld_q1 <= 1'b0;
      err_q1 <= 1'b0;
    end else begin
      vld_q1 <= lkup_hit;
      err_q1 <= lkup_miss;
      if (lkup_hit) msg_q1 <= rd[lk_bank];
    end
  end

`ifdef IBLUT_OUT_REG_EN
  logic [MSG_WIDTH-1:0] msg_q2;
  logic                 vld_q2;
  logic                 err_q2;

  // Extra output stage, all three outputs delayed equally
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      msg_q2 <= '0;
      vld_q2 <= 1'b0;
      err_q2 <= 1'b0;
    end else begin
      msg_q2 <= msg_q1;
      vld_q2 <= vld_q1;
      err_q2 <= err_q1;
    end
  end

  assign msg_o       = msg_q2;
  assign msg_valid_o = vld_q2;
  assign lkup_err_o  = err_q2;
`else
  assign msg_o       = msg_q1;
  assign msg_valid_o = vld_q1;
  assign lkup_err_o  = err_q1;
`endif

endmodule

// File: tb/tb_memshare_vn_iblut_loader_mb.sv
// Directed testbench for memshare_vn_iblut_loader_mb at default parameters.
// Lookup latency follows IBLUT_OUT_REG_EN so the same bench covers both builds.
module tb_memshare_vn_iblut_loader_mb;

`ifdef IBLUT_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start_i = 1'b0;
  logic       remap_valid_i = 1'b0;
  logic [7:0] remap_data_i = '0;
  logic       remap_ready_o;
  logic       load_done_o;
  logic       table_valid_o;
  logic       lkup_valid_i = 1'b0;
  logic [5:0] lkup_addr_i = '0;
  logic [3:0] msg_o;
  logic       msg_valid_o;
  logic       lkup_err_o;
  logic [1:0] grp_o;

  int vec = 0;
  int errs = 0;
  int done_cnt, done_cyc, sent;

  memshare_vn_iblut_loader_mb #(
    .BANK_NUM(2), .ADDR_WIDTH(6), .MSG_WIDTH(4), .SHARE_GROUP(1)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .load_start_i(load_start_i),
    .remap_valid_i(remap_valid_i), .remap_data_i(remap_data_i),
    .remap_ready_o(remap_ready_o), .load_done_o(load_done_o),
    .table_valid_o(table_valid_o), .lkup_valid_i(lkup_valid_i),
    .lkup_addr_i(lkup_addr_i), .msg_o(msg_o), .msg_valid_o(msg_valid_o),
    .lkup_err_o(lkup_err_o), .grp_o(grp_o)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Page word: bank1 = page value, bank0 = its complement (page offset by off)
  function automatic logic [7:0] pat(input int p, input int off);
    int q;
    logic [3:0] v;
    q = p + off;
    v = q[3:0];
    return {v, ~v};
  endfunction

  function automatic logic [3:0] exp_msg(input int a, input int off);
    logic [7:0] w;
    w = pat(a >> 1, off);
    return (a % 2 == 1) ? w[7:4] : w[3:0];
  endfunction

  // Streams n words from page 0, optionally valid only every other cycle
  task automatic stream(input int n, input bit toggle, input int off);
    int cyc;
    bit v;
    cyc = 0; sent = 0; done_cnt = 0; done_cyc = 0;
    while (sent < n && cyc < 300) begin
      cyc++;
      v = toggle ? ((cyc % 2) == 1) : 1'b1;
      remap_valid_i = v;
      remap_data_i  = pat(sent, off);
      if (v) begin
        vec++;
        if (remap_ready_o !== 1'b1) begin
          errs++;
          $display("FAIL ready_in_load: page %0d got %b expected 1", sent, remap_ready_o);
        end
      end
      tick();
      if (v) sent++;
      if (load_done_o === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        vec++;
        if (table_valid_o !== 1'b1) begin
          errs++;
          $display("FAIL valid_with_done: got %b expected 1", table_valid_o);
        end
      end else if (table_valid_o !== 1'b0) begin
        vec++;
        errs++;
        $display("FAIL valid_during_load: cycle %0d got %b expected 0", cyc, table_valid_o);
      end
    end
    remap_valid_i = 1'b0;
  endtask

  task automatic check_err_lookup(input logic [5:0] a);
    lkup_valid_i = 1'b1;
    lkup_addr_i  = a;
    tick();
    lkup_valid_i = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
    vec++;
    if (lkup_err_o !== 1'b1 || msg_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL err_lookup: err %b valid %b expected err 1 valid 0", lkup_err_o, msg_valid_o);
    end
    tick();
    vec++;
    if (lkup_err_o !== 1'b0) begin
      errs++;
      $display("FAIL err_pulse_end: got %b expected 0", lkup_err_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vec++;
    if ({remap_ready_o, load_done_o, table_valid_o, msg_valid_o, lkup_err_o} !== 5'b0 ||
        msg_o !== 4'h0 || grp_o !== 2'd1) begin
      errs++;
      $display("FAIL reset_state: rdy %b done %b tv %b mv %b err %b msg %h grp %0d expected zeros, grp 1",
               remap_ready_o, load_done_o, table_valid_o, msg_valid_o, lkup_err_o, msg_o, grp_o);
    end
    check_err_lookup(6'd5);
    vec++;
    if (table_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL empty_table_valid: got %b expected 0", table_valid_o);
    end
  endtask

  task automatic do_load(input bit toggle, input int off, input int exp_cyc);
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    stream(32, toggle, off);
    vec++;
    if (sent !== 32 || done_cnt !== 1 || done_cyc !== exp_cyc) begin
      errs++;
      $display("FAIL load_done: sent %0d pulses %0d at cycle %0d expected 32, 1, %0d",
               sent, done_cnt, done_cyc, exp_cyc);
    end
    tick();
    vec++;
    if (load_done_o !== 1'b0 || table_valid_o !== 1'b1 || remap_ready_o !== 1'b0) begin
      errs++;
      $display("FAIL after_load: done %b tv %b rdy %b expected 0 1 0",
               load_done_o, table_valid_o, remap_ready_o);
    end
  endtask

  task automatic test_full_load();
    do_load(1'b0, 0, 32);
  endtask

  task automatic lookup(input logic [5:0] a, input logic [3:0] e);
    lkup_valid_i = 1'b1;
    lkup_addr_i  = a;
    tick();
    lkup_valid_i = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      vec++;
      if (msg_valid_o !== 1'b0) begin
        errs++;
        $display("FAIL lookup_early: addr %h valid %b expected 0", a, msg_valid_o);
      end
      tick();
    end
    vec++;
    if (msg_valid_o !== 1'b1 || msg_o !== e || lkup_err_o !== 1'b0) begin
      errs++;
      $display("FAIL lookup: addr %h got %h valid %b err %b expected %h valid 1 err 0",
               a, msg_o, msg_valid_o, lkup_err_o, e);
    end
    tick();
    vec++;
    if (msg_valid_o !== 1'b0 || msg_o !== e) begin
      errs++;
      $display("FAIL lookup_hold: addr %h got %h valid %b expected %h valid 0", a, msg_o, msg_valid_o, e);
    end
  endtask

  task automatic test_lookup();
    lookup(6'h0B, 4'h5);
    lookup(6'h0A, 4'hA);
    lookup(6'h3F, 4'hF);
  endtask

  task automatic test_back_to_back(input int off);
    int k;
    int got;
    got = 0;
    for (int i = 0; i < 64 + LAT - 1; i++) begin
      lkup_valid_i = (i < 64);
      lkup_addr_i  = 6'(i);
      tick();
      k = i - (LAT - 1);
      if (k >= 0) begin
        vec++;
        if (msg_valid_o === 1'b1) got++;
        if (msg_valid_o !== 1'b1 || msg_o !== exp_msg(k, off)) begin
          errs++;
          $display("FAIL b2b: addr %0d got %h valid %b expected %h valid 1",
                   k, msg_o, msg_valid_o, exp_msg(k, off));
        end
      end
    end
    lkup_valid_i = 1'b0;
    tick();
    vec++;
    if (got !== 64 || msg_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL b2b_count: got %0d results, trailing valid %b expected 64, 0", got, msg_valid_o);
    end
  endtask

  task automatic test_toggle_load();
    do_load(1'b1, 7, 63);
    test_back_to_back(7);
  endtask

  task automatic test_restart();
    // Reload from ACTIVE with a same-cycle lookup that must still complete
    load_start_i = 1'b1;
    lkup_valid_i = 1'b1;
    lkup_addr_i  = 6'h0B;
    tick();
    load_start_i = 1'b0;
    lkup_valid_i = 1'b0;
    vec++;
    if (table_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL reload_drop_valid: got %b expected 0", table_valid_o);
    end
    for (int i = 1; i < LAT; i++) tick();
    vec++;
    if (msg_valid_o !== 1'b1 || msg_o !== exp_msg(11, 7)) begin
      errs++;
      $display("FAIL reload_lookup: got %h valid %b expected %h valid 1", msg_o, msg_valid_o, exp_msg(11, 7));
    end
    stream(10, 1'b0, 3);
    // Restart at page 10 with a word accepted in the same cycle
    load_start_i  = 1'b1;
    remap_valid_i = 1'b1;
    remap_data_i  = 8'hFF;
    tick();
    load_start_i  = 1'b0;
    remap_valid_i = 1'b0;
    vec++;
    if (table_valid_o !== 1'b0 || load_done_o !== 1'b0) begin
      errs++;
      $display("FAIL restart_state: tv %b done %b expected 0 0", table_valid_o, load_done_o);
    end
    stream(32, 1'b0, 0);
    vec++;
    if (done_cnt !== 1 || done_cyc !== 32) begin
      errs++;
      $display("FAIL restart_done: pulses %0d at cycle %0d expected 1 at 32", done_cnt, done_cyc);
    end
    tick();
    test_back_to_back(0);
  endtask

  task automatic test_reset_mid_load();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    stream(10, 1'b0, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++;
    if (table_valid_o !== 1'b0 || remap_ready_o !== 1'b0 || msg_valid_o !== 1'b0 || msg_o !== 4'h0) begin
      errs++;
      $display("FAIL mid_reset_state: tv %b rdy %b mv %b msg %h expected 0 0 0 0",
               table_valid_o, remap_ready_o, msg_valid_o, msg_o);
    end
    check_err_lookup(6'h0B);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_lookup();
    test_back_to_back(0);
    test_toggle_load();
    test_restart();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
